// File: rtl/transformer_pkg.sv
// Shared types for the transform front end: FSM state encoding, vertex,
// transform, triangle and setup-entry layouts, and the back colour reset value.
package transformer_pkg;

  typedef enum logic [3:0] {
    IDLE, INST_REQ, INST_WAIT, CAM_EMIT, TRI_REQ, TRI_WAIT, VERT_WAIT, EMIT, DONE
  } frame_state_t;

  localparam logic [15:0] BACK_COLOR_RST = 16'h2106;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
  } vertex_t;

  typedef struct packed {
    logic [3:0][15:0] m;
  } transform_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic       camera_transform_valid;
    transform_t camera_transform;
    logic       model_transform_valid;
    transform_t model_transform;
    triangle_t  triangle;
  } transform_setup_t;

endpackage

// File: rtl/setup_fifo.sv
// Small FIFO with a registered head: dout always holds the oldest entry
// (zero when empty). flush empties it in one cycle. DEPTH is a power of two.
module setup_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr, rnext;
  logic [AW:0]      count;
  logic             wr, rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rnext = rptr + 1'b1;

  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // pointers, occupancy and the registered head entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0; rptr <= '0; count <= '0; dout <= '0;
    end else if (flush) begin
      wptr <= '0; rptr <= '0; count <= '0; dout <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rnext;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      if (rd) begin
        if (count == (AW+1)'(1)) dout <= wr ? din : '0;
        else                     dout <= mem[rnext];
      end else if (wr && empty) begin
        dout <= din;
      end
    end
  end
endmodule

// File: rtl/frame_stream_driver.sv
// Walks the instance list once per frame: a camera entry for instance 0, then
// one setup entry per triangle of each model instance, through an output FIFO.
// Optional FRAME_STREAM_STATS_EN adds a tri_emitted counter output.
module frame_stream_driver
  import transformer_pkg::*;
#(
  parameter int MAX_VERT   = 8192,
  parameter int MAX_TRI    = 8192,
  parameter int MAX_INST   = 256,
  parameter int VIDX_W     = 8,
  parameter int TIDX_W     = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int VADDR_W   = $clog2(MAX_VERT),
  localparam int TADDR_W   = $clog2(MAX_TRI),
  localparam int IID_W     = $clog2(MAX_INST)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scene_ready,
  input  logic [IID_W-1:0]   max_inst,
  input  logic               frame_start,
  output logic [IID_W-1:0]   inst_id_rd,
  input  logic [VADDR_W-1:0] inst_vert_base,
  input  logic [TADDR_W-1:0] inst_tri_base,
  input  logic [TIDX_W-1:0]  inst_tri_count,
  output logic [TADDR_W-1:0] tri_addr,
  input  logic [3*VIDX_W-1:0] tri_data,
  output logic [VADDR_W-1:0] vert_addr,
  input  vertex_t            vert_data,
  input  transform_t         xf_in,
  input  logic [15:0]        id_data,
  output logic               out_valid,
  input  logic               out_ready,
  output transform_setup_t   out_setup,
  output logic [15:0]        back_color,
  output logic               frame_done,
  output logic               busy
`ifdef FRAME_STREAM_STATS_EN
  ,
  output logic [31:0]        tri_emitted
`endif
);
  frame_state_t     state, state_n;
  logic [1:0]       rdy_sync;
  logic [IID_W-1:0] mi_s1, mi_s;
  logic             scene_s, empty, full, push, abort, start_ok, last_inst, last_tri;
  logic [IID_W-1:0] inst;
  logic [2:0]       cnt;
  logic [TIDX_W-1:0] tri_ctr, d_tcnt;
  logic [VADDR_W-1:0] d_vbase;
  logic [TADDR_W-1:0] d_tbase;
  transform_t       d_xf;
  logic [15:0]      d_id;
  logic [3*VIDX_W-1:0] tri_q;
  vertex_t          v0_q, v1_q, v2_q;
  transform_setup_t din;

  assign scene_s   = rdy_sync[1];
  assign start_ok  = frame_start && scene_s && (state == IDLE || state == DONE);
  assign last_inst = (inst == mi_s);
  assign last_tri  = (tri_ctr == d_tcnt - 1'b1);
  assign out_valid = !empty;
  assign busy      = (state != IDLE && state != DONE) || !empty;
  assign abort     = !scene_s && busy;

  // two-flop synchronisers for the asynchronous scene controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_sync <= '0; mi_s1 <= '0; mi_s <= '0;
    end else begin
      rdy_sync <= {rdy_sync[0], scene_ready};
      mi_s1    <= max_inst;
      mi_s     <= mi_s1;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state and FIFO push
  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE, DONE: if (start_ok) state_n = INST_REQ;
      INST_REQ:   state_n = INST_WAIT;
      INST_WAIT:
        if (cnt == 3'(RD_LAT - 1)) begin
          if (inst == '0)                state_n = CAM_EMIT;
          else if (inst_tri_count == '0) state_n = last_inst ? DONE : INST_REQ;
          else                           state_n = TRI_REQ;
        end
      CAM_EMIT:
        if (!full) begin
          push    = 1'b1;
          state_n = last_inst ? DONE : INST_REQ;
        end
      TRI_REQ:    state_n = TRI_WAIT;
      TRI_WAIT:   if (cnt == 3'(RD_LAT - 1)) state_n = VERT_WAIT;
      VERT_WAIT:  if (cnt == 3'(RD_LAT + 2)) state_n = EMIT;
      EMIT:
        if (!full) begin
          push = 1'b1;
          if (!last_tri)      state_n = TRI_REQ;
          else if (last_inst) state_n = DONE;
          else                state_n = INST_REQ;
        end
      default:    state_n = IDLE;
    endcase
    if (abort) begin
      state_n = IDLE;
      push    = 1'b0;
    end
  end

  // RAM addresses are driven only in their issue cycles, zero otherwise
  always_comb begin
    inst_id_rd = (state == INST_REQ) ? inst : '0;
    tri_addr   = (state == TRI_REQ) ? d_tbase + TADDR_W'(tri_ctr) : '0;
    vert_addr  = '0;
    if (state == VERT_WAIT) begin
      case (cnt)
        3'd0:    vert_addr = d_vbase + VADDR_W'(tri_q[3*VIDX_W-1 -: VIDX_W]);
        3'd1:    vert_addr = d_vbase + VADDR_W'(tri_q[2*VIDX_W-1 -: VIDX_W]);
        3'd2:    vert_addr = d_vbase + VADDR_W'(tri_q[VIDX_W-1:0]);
        default: vert_addr = '0;
      endcase
    end
  end

  // entry assembly: camera entry or model triangle entry
  always_comb begin
    din = '0;
    if (state == CAM_EMIT) begin
      din.camera_transform_valid = 1'b1;
      din.camera_transform       = d_xf;
    end else begin
      din.model_transform_valid = 1'b1;
      din.model_transform       = d_xf;
      din.triangle              = '{v0: v0_q, v1: v1_q, v2: v2_q};
    end
  end

  // walk counters, descriptor/triangle/vertex capture, frame status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst <= '0; cnt <= '0; tri_ctr <= '0; d_tcnt <= '0;
      d_vbase <= '0; d_tbase <= '0; d_xf <= '0; d_id <= '0;
      tri_q <= '0; v0_q <= '0; v1_q <= '0; v2_q <= '0;
      back_color <= BACK_COLOR_RST; frame_done <= 1'b0;
    end else begin
      cnt <= (state_n != state) ? 3'd0 : cnt + 3'd1;
      if (start_ok) inst <= '0;
      else if (state_n == INST_REQ && state != IDLE && state != DONE) inst <= inst + 1'b1;
      if (state == INST_WAIT && cnt == 3'(RD_LAT - 1)) begin
        d_vbase <= inst_vert_base; d_tbase <= inst_tri_base; d_tcnt <= inst_tri_count;
        d_xf <= xf_in; d_id <= id_data; tri_ctr <= '0;
      end
      if (state == EMIT && push && !last_tri) tri_ctr <= tri_ctr + 1'b1;
      if (state == TRI_WAIT && cnt == 3'(RD_LAT - 1)) tri_q <= tri_data;
      if (state == VERT_WAIT) begin
        if (cnt == 3'(RD_LAT))     v0_q <= vert_data;
        if (cnt == 3'(RD_LAT + 1)) v1_q <= vert_data;
        if (cnt == 3'(RD_LAT + 2)) v2_q <= vert_data;
      end
      if (state == CAM_EMIT && push) back_color <= d_id;
      if (abort || start_ok)              frame_done <= 1'b0;
      else if (state == DONE && empty)    frame_done <= 1'b1;
    end
  end

`ifdef FRAME_STREAM_STATS_EN
  // model-triangle push counter, saturating, cleared per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        tri_emitted <= '0;
    else if (start_ok)                              tri_emitted <= '0;
    else if (push && state == EMIT && !(&tri_emitted)) tri_emitted <= tri_emitted + 32'd1;
  end
`endif

  setup_fifo #(.WIDTH($bits(transform_setup_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .din   (din),
    .pop   (out_valid && out_ready),
    .dout  (out_setup),
    .empty (empty),
    .full  (full)
  );
endmodule

// File: tb/tb_frame_stream_driver.sv
// Randomised bench: scene tables in arrays, latency-RD_LAT RAM models, and a
// frame model that lists the expected setup entries in stream order.
module tb_frame_stream_driver;
  import transformer_pkg::*;
  localparam int MAX_VERT = 8192, MAX_TRI = 8192, MAX_INST = 256;
  localparam int VIDX_W = 8, TIDX_W = 8, RD_LAT = 2, FIFO_DEPTH = 4;
  localparam int VADDR_W = $clog2(MAX_VERT), TADDR_W = $clog2(MAX_TRI), IID_W = $clog2(MAX_INST);

  logic clk, rst, scene_ready, frame_start, out_valid, out_ready, frame_done, busy;
  logic [IID_W-1:0] max_inst, inst_id_rd;
  logic [VADDR_W-1:0] inst_vert_base, vert_addr;
  logic [TADDR_W-1:0] inst_tri_base, tri_addr;
  logic [TIDX_W-1:0] inst_tri_count;
  logic [3*VIDX_W-1:0] tri_data;
  vertex_t vert_data;
  transform_t xf_in;
  logic [15:0] id_data, back_color;
  transform_setup_t out_setup;
`ifdef FRAME_STREAM_STATS_EN
  logic [31:0] tri_emitted;
`endif

  frame_stream_driver #(.MAX_VERT(MAX_VERT), .MAX_TRI(MAX_TRI), .MAX_INST(MAX_INST),
    .VIDX_W(VIDX_W), .TIDX_W(TIDX_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .scene_ready(scene_ready), .max_inst(max_inst),
    .frame_start(frame_start), .inst_id_rd(inst_id_rd), .inst_vert_base(inst_vert_base),
    .inst_tri_base(inst_tri_base), .inst_tri_count(inst_tri_count), .tri_addr(tri_addr),
    .tri_data(tri_data), .vert_addr(vert_addr), .vert_data(vert_data), .xf_in(xf_in),
    .id_data(id_data), .out_valid(out_valid), .out_ready(out_ready), .out_setup(out_setup),
    .back_color(back_color), .frame_done(frame_done), .busy(busy)
`ifdef FRAME_STREAM_STATS_EN
    , .tri_emitted(tri_emitted)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scene content
  logic [VADDR_W-1:0] t_vb [MAX_INST];
  logic [TADDR_W-1:0] t_tb [MAX_INST];
  logic [TIDX_W-1:0]  t_tc [MAX_INST];
  transform_t         t_xf [MAX_INST];
  logic [15:0]        t_id [MAX_INST];
  logic [23:0]        tri_mem [MAX_TRI];
  vertex_t            vert_mem [MAX_VERT];

  // RAM read latency: address pipelines of RD_LAT stages
  logic [IID_W-1:0]   ia_d [RD_LAT];
  logic [TADDR_W-1:0] ta_d [RD_LAT];
  logic [VADDR_W-1:0] va_d [RD_LAT];
  always @(posedge clk) begin
    ia_d[0] <= inst_id_rd; ta_d[0] <= tri_addr; va_d[0] <= vert_addr;
    for (int k = 1; k < RD_LAT; k++) begin
      ia_d[k] <= ia_d[k-1]; ta_d[k] <= ta_d[k-1]; va_d[k] <= va_d[k-1];
    end
  end
  assign inst_vert_base = t_vb[ia_d[RD_LAT-1]];
  assign inst_tri_base  = t_tb[ia_d[RD_LAT-1]];
  assign inst_tri_count = t_tc[ia_d[RD_LAT-1]];
  assign xf_in          = t_xf[ia_d[RD_LAT-1]];
  assign id_data        = t_id[ia_d[RD_LAT-1]];
  assign tri_data       = tri_mem[ta_d[RD_LAT-1]];
  assign vert_data      = vert_mem[va_d[RD_LAT-1]];

  int n_pass = 0, n_chk = 0, n_pop = 0, n_model = 0;
  transform_setup_t exp_q[$];
  logic sb_en = 1'b0, stall = 1'b0, rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // expected stream: camera entry, then every triangle of instances 1..mi in order
  task automatic build_model(input int mi);
    transform_setup_t e;
    logic [23:0] w;
    exp_q.delete(); n_model = 0;
    e = '0; e.camera_transform_valid = 1'b1; e.camera_transform = t_xf[0];
    exp_q.push_back(e);
    for (int i = 1; i <= mi; i++)
      for (int t = 0; t < int'(t_tc[i]); t++) begin
        w = tri_mem[(int'(t_tb[i]) + t) % MAX_TRI];
        e = '0; e.model_transform_valid = 1'b1; e.model_transform = t_xf[i];
        e.triangle.v0 = vert_mem[(int'(t_vb[i]) + int'(w[23:16])) % MAX_VERT];
        e.triangle.v1 = vert_mem[(int'(t_vb[i]) + int'(w[15:8]))  % MAX_VERT];
        e.triangle.v2 = vert_mem[(int'(t_vb[i]) + int'(w[7:0]))   % MAX_VERT];
        exp_q.push_back(e); n_model++;
      end
  endtask

  // output ready pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall)        out_ready = 1'b0;
      else if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      else              out_ready = 1'b1;
    end
  end

  // scoreboard: every accepted entry against the model, and hold-stability
  logic p_valid = 1'b0, p_ready = 1'b0;
  transform_setup_t p_setup = '0;
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (p_valid && !p_ready) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_setup, p_setup);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_entry", 1, 0);
        else chk($sformatf("entry%0d", n_pop), out_setup, exp_q.pop_front());
        n_pop++;
      end
    end
    p_valid = out_valid; p_ready = out_ready; p_setup = out_setup;
  end

  task automatic pulse_start();
    frame_start = 1'b1; @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic run_frame(input int mi, input string tag);
    int cyc;
    max_inst = IID_W'(mi);
    repeat (3) @(posedge clk); #1;
    build_model(mi); n_pop = 0;
    pulse_start();
    chk({tag, "_done_clr"}, frame_done, 0);
    chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!frame_done && cyc < 4000) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_done"}, frame_done, 1);
    chk({tag, "_count"}, n_pop, 1 + n_model);
    chk({tag, "_back"}, back_color, t_id[0]);
    chk({tag, "_idle"}, busy, 0);
`ifdef FRAME_STREAM_STATS_EN
    chk({tag, "_stats"}, tri_emitted, n_model);
`endif
  endtask

  task automatic rand_inst(input int i, input int max_tc);
    t_vb[i] = VADDR_W'($urandom()); t_tb[i] = TADDR_W'($urandom());
    t_tc[i] = TIDX_W'($urandom_range(0, max_tc));
    t_xf[i].m = {$urandom(), $urandom()}; t_id[i] = 16'($urandom());
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; scene_ready = 1'b0; max_inst = '0; frame_start = 1'b0;
    for (int a = 0; a < MAX_TRI; a++) tri_mem[a] = 24'($urandom());
    for (int a = 0; a < MAX_VERT; a++) begin
      vert_mem[a].x = 16'($urandom()); vert_mem[a].y = 16'($urandom()); vert_mem[a].z = 16'($urandom());
    end
    for (int i = 0; i < MAX_INST; i++) rand_inst(i, 5);
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_back", back_color, 16'h2106);
    chk("rst_iaddr", inst_id_rd, 0);
    chk("rst_taddr", tri_addr, 0);
    chk("rst_vaddr", vert_addr, 0);
    chk("rst_setup", out_setup, 0);
    @(posedge clk); #1 rst = 1'b0;
    sb_en = 1'b1;

    // start without a loaded scene is ignored
    pulse_start();
    repeat (3) @(posedge clk); #1;
    chk("noscene_busy", busy, 0);
    scene_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // camera-only frame
    t_id[0] = 16'hBEEF;
    run_frame(0, "cam");
    chk("cam_back_lit", back_color, 16'hBEEF);
    chk("cam_n_lit", n_pop, 1);

    // two model instances, 3 and 2 triangles, with pinned model content
    t_tc[1] = 3; t_tc[2] = 2; t_tb[1] = 10; t_vb[1] = 100;
    tri_mem[10] = 24'h010203; vert_mem[101] = 48'h1111_2222_3333;
    build_model(2);
    chk("model_size_lit", exp_q.size(), 6);
    chk("model_v0_lit", exp_q[1].triangle.v0, 48'h1111_2222_3333);
    rnd_rdy = 1'b1;
    run_frame(2, "two");

    // empty instance is skipped
    t_tc[1] = 0;
    run_frame(2, "skip");
    chk("skip_n_lit", n_pop, 3);

    // long back-pressure mid-frame, with an ignored frame_start
    t_tc[1] = 8; t_tc[2] = 8;
    fork
      run_frame(2, "stall");
      begin
        repeat (12) @(posedge clk);
        stall = 1'b1;
        repeat (5) @(posedge clk); #1;
        pulse_start();
        repeat (14) @(posedge clk); #1;
        chk("stall_valid", out_valid, 1);
        chk("stall_busy", busy, 1);
        stall = 1'b0;
      end
    join

    // address wrap-around at the top of both RAMs
    t_tb[1] = TADDR_W'(MAX_TRI - 1); t_tc[1] = 3; t_vb[1] = VADDR_W'(MAX_VERT - 2);
    run_frame(1, "wrap");

    // random scenes
    for (int f = 0; f < 8; f++) begin
      int mi;
      mi = $urandom_range(0, 5);
      for (int i = 0; i <= mi; i++) rand_inst(i, 5);
      run_frame(mi, $sformatf("rnd%0d", f));
    end

    // scene_ready dropped mid-frame
    for (int i = 0; i <= 3; i++) t_tc[i] = 8;
    max_inst = 3; stall = 1'b1;
    repeat (3) @(posedge clk); #1;
    sb_en = 1'b0;
    pulse_start();
    repeat (15) @(posedge clk); #1;
    chk("abort_pre_busy", busy, 1);
    scene_ready = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    stall = 1'b0; exp_q.delete();
    scene_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    sb_en = 1'b1;
    t_tc[1] = 2;
    run_frame(1, "recover");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/frame_stream_driver.md
FRAME_STREAM_DRIVER -- requirements
Module: frame_stream_driver

Interface
REQ-001 Parameter MAX_VERT, 8192, vertex RAM depth; VADDR_W = $clog2(MAX_VERT).
REQ-002 Parameter MAX_TRI, 8192, triangle RAM depth; TADDR_W = $clog2(MAX_TRI).
REQ-003 Parameter MAX_INST, 256, instance slots; IID_W = $clog2(MAX_INST).
REQ-004 Parameter VIDX_W, 8, per-instance vertex index width; triangle word is 3*VIDX_W, with v0 in the MSBs.
REQ-005 Parameter TIDX_W, 8, per-instance triangle count width.
REQ-006 Parameter RD_LAT, 2, cycles from address to valid data on every RAM port (1..4).
REQ-007 Parameter FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2).
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  reset: asynchronous, active-high.
REQ-010 scene_ready  in  1  scene loaded (asynchronous source, level).
REQ-011 max_inst  in  IID_W  highest model instance id (asynchronous source).
REQ-012 frame_start  in  1  one-cycle request to stream one frame.
REQ-013 inst_id_rd  out  IID_W  instance/transform/id RAM address.
REQ-014 inst_vert_base / inst_tri_base / inst_tri_count  in  VADDR_W / TADDR_W / TIDX_W  descriptor, valid RD_LAT after inst_id_rd.
REQ-015 tri_addr  out  TADDR_W; tri_data  in  3*VIDX_W.
REQ-016 vert_addr  out  VADDR_W; vert_data  in  vertex_t.
REQ-017 xf_in  in  transform_t; id_data  in  16  instance colour word.
REQ-018 out_valid  out  1; out_ready  in  1; out_setup  out  transform_setup_t.
REQ-019 back_color  out  16; frame_done  out  1; busy  out  1.

Function
REQ-020 scene_ready and max_inst SHALL pass through 2-FF synchronisers; only the synchronised values are used.
REQ-021 FSM states: IDLE, INST_REQ, INST_WAIT, CAM_EMIT, TRI_REQ, TRI_WAIT, VERT_WAIT, EMIT, DONE.
REQ-022 IDLE→INST_REQ on frame_start with synchronised scene_ready high; inst id is set to 0. frame_start SHALL be ignored outside IDLE/DONE.
REQ-023 INST_WAIT SHALL wait exactly RD_LAT cycles, then register the descriptor, xf_in and id_data.
REQ-024 Instance 0 → CAM_EMIT: push one entry with camera_transform_valid=1 and camera_transform=xf_in; set back_color=id_data; then go to the next instance.
REQ-025 A model instance with tri_count==0 SHALL be skipped without pushing an entry.
REQ-026 TRI_REQ: tri_addr=tri_base+tri_ctr, with TADDR_W wrap-around. After RD_LAT cycles, issue vert_addr=vert_base+v0, v1, v2 on consecutive cycles.
REQ-027 VERT_WAIT SHALL capture v0, v1 and v2 at RD_LAT, RD_LAT+1 and RD_LAT+2 after the v0 issue.
REQ-028 EMIT: push triangle, model_transform and model_transform_valid=1. If the FIFO is full, hold in EMIT with no loss.
REQ-029 After the last triangle (tri_ctr==tri_count-1): if inst==max_inst, go to DONE; otherwise inst+1 → INST_REQ.
REQ-030 max_inst==0: the frame SHALL be the camera entry only.
REQ-031 out_valid = FIFO not empty. out_setup is stable while out_valid && !out_ready. A pop happens on out_valid && out_ready.
REQ-032 frame_done SHALL rise one cycle after the FSM is in DONE and the FIFO is empty. It holds until the next accepted frame_start.
REQ-033 busy = FSM not in IDLE/DONE, or FIFO not empty.
REQ-034 Falling synchronised scene_ready mid-frame SHALL abort to IDLE, flush the FIFO and leave frame_done low.
REQ-035 Addresses not in use SHALL read 0.

Reset
REQ-036 Reset values: FSM IDLE, FIFO empty, out_valid 0, all addresses 0, tri_ctr 0, back_color 16'h2106, frame_done 0, busy 0, synchronisers 0, out_setup 0.

Configuration
REQ-037 With FRAME_STREAM_STATS_EN defined: add output tri_emitted (32 bits), which counts FIFO pushes with model_transform_valid. It clears on accepted frame_start and saturates at all-ones.
REQ-038 Without FRAME_STREAM_STATS_EN: no port and no counter logic.

Structure
REQ-039 FIFO_DEPTH-independent typedefs (frame_state_t) and the constant BACK_COLOR_RST=16'h2106 SHALL live in transformer_pkg; transform_t, transform_setup_t and triangle_t are reused from it.
REQ-040 The output FIFO SHALL be sub-module setup_fifo (parametrised width/depth, registered output).

Verification
REQ-041 max_inst=0, frame_start → exactly one entry with camera_transform_valid, back_color=id_data of instance 0, then frame_done=1.
REQ-042 max_inst=2, tri_counts 3/2 → 1 camera + 5 model entries, in order, with correct v0/v1/v2 from base+index.
REQ-043 out_ready low for 20 cycles mid-frame → FIFO fills, EMIT stalls, zero entries lost or duplicated.
REQ-044 Instance 1 tri_count=0, max_inst=2 → no entries for instance 1; instance 2 streamed.
REQ-045 RD_LAT=1 and RD_LAT=4 builds → identical output sequences to the RD_LAT=2 build.
REQ-046 scene_ready dropped mid-frame → IDLE, out_valid 0 within 4 cycles, frame_done 0.
